// File: rtl/risc16_pkg.sv
// Shared opcodes, FSM states and instruction field helpers for the RiSC-16 core.
package risc16_pkg;

  localparam int unsigned XLEN = 16;
  localparam int unsigned NREG = 8;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_LUI  = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_JALR = 3'd7;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  function automatic logic [2:0] f_op(input logic [15:0] ir);
    return ir[15:13];
  endfunction

  function automatic logic [2:0] f_ra(input logic [15:0] ir);
    return ir[12:10];
  endfunction

  function automatic logic [2:0] f_rb(input logic [15:0] ir);
    return ir[9:7];
  endfunction

  function automatic logic [2:0] f_rc(input logic [15:0] ir);
    return ir[2:0];
  endfunction

  function automatic logic [6:0] f_simm7(input logic [15:0] ir);
    return ir[6:0];
  endfunction

  function automatic logic [9:0] f_imm10(input logic [15:0] ir);
    return ir[9:0];
  endfunction

  function automatic logic [15:0] sext7(input logic [6:0] v);
    return {{9{v[6]}}, v};
  endfunction

endpackage

// File: rtl/risc16_regfile.sv
// 8x16 register file: two async read ports, one sync write port, r0 hard-wired to zero.
module risc16_regfile (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [2:0]  i_raddr_a,
  output logic [15:0] o_rdata_a,
  input  logic [2:0]  i_raddr_b,
  output logic [15:0] o_rdata_b,
  input  logic        i_we,
  input  logic [2:0]  i_waddr,
  input  logic [15:0] i_wdata
);
  import risc16_pkg::*;

  logic [XLEN-1:0] r_regs [NREG];

  // Register storage; writes to r0 are dropped
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) r_regs[3'(i)] <= '0;
    end else if (i_we && (i_waddr != 3'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == 3'd0) ? '0 : r_regs[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == 3'd0) ? '0 : r_regs[i_raddr_b];

endmodule

// File: rtl/risc16_mc_core.sv
// Multi-cycle RiSC-16 core with req/ack instruction and data memory ports.
module risc16_mc_core #(
  parameter int unsigned        ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              i_clk0,
  input  logic              i_reset,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [15:0]       i_imem_rdata,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [15:0]       o_dmem_wdata,
  input  logic              i_dmem_ack,
  input  logic [15:0]       i_dmem_rdata,
  output logic              o_retire,
  output logic              o_halted
);
  import risc16_pkg::*;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_ir;
  logic              r_imem_req;
  logic              r_dmem_req;
  logic              r_dmem_we;
  logic [ADDR_W-1:0] r_dmem_addr;
  logic [15:0]       r_dmem_wdata;
  logic              r_retire;
  logic              r_halted;

  logic [2:0]        w_op;
  logic [2:0]        w_ra;
  logic [2:0]        w_x_addr;
  logic [15:0]       w_simm;
  logic [15:0]       w_b_val;
  logic [15:0]       w_x_val;
  logic [15:0]       w_sum;
  logic [15:0]       w_br_tgt;
  logic [15:0]       w_alu;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_is_mem;
  logic              w_is_halt;
  logic              w_mem_done;
  logic              w_rf_we;
  logic [15:0]       w_rf_wdata;

  assign w_op      = f_op(r_ir);
  assign w_ra      = f_ra(r_ir);
  assign w_simm    = sext7(f_simm7(r_ir));
  assign w_x_addr  = ((w_op == OP_ADD) || (w_op == OP_NAND)) ? f_rc(r_ir) : w_ra;
  assign w_sum     = w_b_val + w_simm;
  assign w_pc_inc  = r_pc + ADDR_W'(1);
  assign w_br_tgt  = 16'(r_pc) + 16'd1 + w_simm;
  assign w_is_mem  = (w_op == OP_SW) || (w_op == OP_LW);
  assign w_is_halt = (w_op == OP_JALR) && (f_simm7(r_ir) != 7'd0);
  assign w_mem_done = (r_state == ST_MEM) && r_dmem_req && i_dmem_ack;

  risc16_regfile u_regfile (
    .i_clk     (i_clk0),
    .i_rst_n   (i_reset),
    .i_raddr_a (f_rb(r_ir)),
    .o_rdata_a (w_b_val),
    .i_raddr_b (w_x_addr),
    .o_rdata_b (w_x_val),
    .i_we      (w_rf_we),
    .i_waddr   (w_ra),
    .i_wdata   (w_rf_wdata)
  );

  // ALU result for register-writing instructions
  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = w_b_val + w_x_val;
      OP_ADDI: w_alu = w_sum;
      OP_NAND: w_alu = ~(w_b_val & w_x_val);
      OP_LUI:  w_alu = {f_imm10(r_ir), 6'b0};
      OP_JALR: w_alu = 16'(w_pc_inc);
      default: w_alu = '0;
    endcase
  end

  // Next PC after a non-memory instruction
  always_comb begin
    w_next_pc = w_pc_inc;
    if ((w_op == OP_BEQ) && (w_x_val == w_b_val)) w_next_pc = w_br_tgt[ADDR_W-1:0];
    else if (w_op == OP_JALR)                     w_next_pc = w_b_val[ADDR_W-1:0];
  end

  // Register write: ALU/LUI/JALR in EXEC, load data on the MEM ack
  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_wdata = w_alu;
    if (r_state == ST_EXEC) begin
      w_rf_we = !w_is_mem && !w_is_halt && (w_op != OP_BEQ);
    end else if (w_mem_done && (w_op == OP_LW)) begin
      w_rf_we    = 1'b1;
      w_rf_wdata = i_dmem_rdata;
    end
  end

  // Control FSM with registered request, retire and halt outputs
  always_ff @(posedge i_clk0 or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= ST_FETCH;
      r_pc         <= RESET_PC;
      r_ir         <= '0;
      r_imem_req   <= 1'b0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_retire     <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_retire <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          if (r_imem_req && i_imem_ack) begin
            r_ir       <= i_imem_rdata;
            r_imem_req <= 1'b0;
            r_retire   <= !((f_op(i_imem_rdata) == OP_LW) || (f_op(i_imem_rdata) == OP_SW));
            r_state    <= ST_EXEC;
          end else begin
            r_imem_req <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (w_is_mem) begin
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= (w_op == OP_SW);
            r_dmem_addr  <= w_sum[ADDR_W-1:0];
            r_dmem_wdata <= w_x_val;
            r_state      <= ST_MEM;
          end else if (w_is_halt) begin
            r_halted <= 1'b1;
            r_state  <= ST_HALT;
          end else begin
            r_pc       <= w_next_pc;
            r_imem_req <= 1'b1;
            r_state    <= ST_FETCH;
          end
        end
        ST_MEM: begin
          if (i_dmem_ack) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_pc       <= w_pc_inc;
            r_imem_req <= 1'b1;
            r_state    <= ST_FETCH;
          end
        end
        ST_HALT: begin
          r_halted <= 1'b1;
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  assign o_imem_req   = r_imem_req;
  assign o_imem_addr  = r_pc;
  assign o_dmem_req   = r_dmem_req;
  assign o_dmem_we    = r_dmem_we;
  assign o_dmem_addr  = r_dmem_addr;
  assign o_dmem_wdata = r_dmem_wdata;
  assign o_retire     = r_retire | w_mem_done;
  assign o_halted     = r_halted;

endmodule

// File: tb/tb_risc16_mc_core.sv
// Directed bench for risc16_mc_core with an ISA-level reference model.
module tb_risc16_mc_core;

  localparam logic [2:0] T_ADD = 3'd0, T_ADDI = 3'd1, T_NAND = 3'd2, T_LUI = 3'd3;
  localparam logic [2:0] T_SW = 3'd4, T_LW = 3'd5, T_BEQ = 3'd6, T_JALR = 3'd7;
  localparam logic [15:0] HALT_W = 16'hE001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire, halted;
  logic [15:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;

  risc16_mc_core dut (
    .i_clk0(clk), .i_reset(rst_n),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata),
    .i_dmem_ack(dmem_ack), .i_dmem_rdata(dmem_rdata), .o_retire(retire), .o_halted(halted)
  );

  logic        rst6_n, req6, ack6, dreq6, dwe6, dack6, ret6, halt6;
  logic [5:0]  addr6, daddr6;
  logic [15:0] rdata6, dwdata6, drdata6;

  risc16_mc_core #(.ADDR_W(6), .RESET_PC(6'd62)) dut6 (
    .i_clk0(clk), .i_reset(rst6_n),
    .o_imem_req(req6), .o_imem_addr(addr6), .i_imem_ack(ack6), .i_imem_rdata(rdata6),
    .o_dmem_req(dreq6), .o_dmem_we(dwe6), .o_dmem_addr(daddr6), .o_dmem_wdata(dwdata6),
    .i_dmem_ack(dack6), .i_dmem_rdata(drdata6), .o_retire(ret6), .o_halted(halt6)
  );

  int n_pass = 0, n_total = 0;
  logic [15:0] imem [256];
  logic [15:0] dmem [256];
  int imem_lat = 0, dmem_lat = 0;

  // reference model state
  logic [15:0] m_pc;
  logic [15:0] m_regs [8];
  logic [15:0] m_dmem [256];
  logic        m_halted;
  logic        chk_en = 1'b0;
  int          cyc, n_ret, n_dreq, first_req;
  int          retire_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [15:0] rrr(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                                      input logic [2:0] c);
    return {op, a, b, 4'b0, c};
  endfunction

  function automatic logic [15:0] rri(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                                      input int imm);
    logic [31:0] t;
    t = imm;
    return {op, a, b, t[6:0]};
  endfunction

  function automatic logic [15:0] ri(input logic [2:0] op, input logic [2:0] a, input logic [9:0] imm);
    return {op, a, imm};
  endfunction

  function automatic logic [15:0] sx(input logic [15:0] ins);
    return {{9{ins[6]}}, ins[6:0]};
  endfunction

  task automatic wr(input logic [2:0] a, input logic [15:0] v);
    if (a != 3'd0) m_regs[a] = v;
  endtask

  // Execute one instruction at the ISA level
  task automatic model_step();
    logic [15:0] ins, ea, t;
    logic [2:0]  a, b, c;
    ins = imem[m_pc[7:0]];
    a = ins[12:10]; b = ins[9:7]; c = ins[2:0];
    ea = m_regs[b] + sx(ins);
    case (ins[15:13])
      T_ADD:  begin wr(a, m_regs[b] + m_regs[c]); m_pc = m_pc + 16'd1; end
      T_ADDI: begin wr(a, ea); m_pc = m_pc + 16'd1; end
      T_NAND: begin wr(a, ~(m_regs[b] & m_regs[c])); m_pc = m_pc + 16'd1; end
      T_LUI:  begin wr(a, {ins[9:0], 6'b0}); m_pc = m_pc + 16'd1; end
      T_SW:   begin m_dmem[ea[7:0]] = m_regs[a]; m_pc = m_pc + 16'd1; end
      T_LW:   begin wr(a, m_dmem[ea[7:0]]); m_pc = m_pc + 16'd1; end
      T_BEQ:  m_pc = (m_regs[a] == m_regs[b]) ? m_pc + 16'd1 + sx(ins) : m_pc + 16'd1;
      default: begin
        if (ins[6:0] != 7'd0) m_halted = 1'b1;
        else begin t = m_regs[b]; wr(a, m_pc + 16'd1); m_pc = t; end
      end
    endcase
  endtask

  // Instruction memory responder with programmable wait states
  initial begin
    int iw;
    iw = 0; imem_ack = 1'b0; imem_rdata = 16'hDEAD;
    forever begin
      @(posedge clk); #1;
      if (imem_req && iw >= imem_lat) begin
        imem_ack = 1'b1; imem_rdata = imem[imem_addr[7:0]]; iw = 0;
      end else begin
        imem_ack = 1'b0; imem_rdata = 16'hDEAD;
        iw = imem_req ? iw + 1 : 0;
      end
    end
  end

  // Data memory responder with programmable wait states
  initial begin
    int dw;
    dw = 0; dmem_ack = 1'b0; dmem_rdata = 16'hDEAD;
    forever begin
      @(posedge clk); #1;
      if (dmem_req && dw >= dmem_lat) begin
        dmem_ack = 1'b1; dw = 0;
        if (dmem_we) dmem[dmem_addr[7:0]] = dmem_wdata;
        dmem_rdata = dmem[dmem_addr[7:0]];
      end else begin
        dmem_ack = 1'b0; dmem_rdata = 16'hDEAD;
        dw = dmem_req ? dw + 1 : 0;
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model
  initial begin
    logic [15:0] ins, ea;
    forever begin
      @(negedge clk);
      if (rst_n && chk_en) begin
        cyc++;
        ins = imem[m_pc[7:0]];
        ea  = m_regs[ins[9:7]] + sx(ins);
        if (imem_req) begin
          if (first_req < 0) first_req = cyc;
          chk("imem_addr", imem_addr, m_pc);
        end
        if (dmem_req) begin
          n_dreq++;
          chk("dmem_addr", dmem_addr, ea);
          chk("dmem_we", dmem_we, ins[15:13] == T_SW);
          if (ins[15:13] == T_SW) chk("dmem_wdata", dmem_wdata, m_regs[ins[12:10]]);
          chk("retire_on_ack", retire, dmem_ack);
        end
        chk("halted", halted, m_halted);
        if (m_halted) chk("halt_quiet", {imem_req, dmem_req, retire}, 3'b000);
        if (retire && !m_halted) begin
          retire_q.push_back(cyc);
          n_ret++;
          model_step();
        end
      end
    end
  end

  task automatic start(input int li, input int ld);
    chk_en = 1'b0; rst_n = 1'b0;
    imem_lat = li; dmem_lat = ld;
    m_pc = 16'd0; m_halted = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'd0;
    for (int i = 0; i < 256; i++) m_dmem[i] = dmem[i];
    retire_q.delete();
    n_ret = 0; n_dreq = 0; cyc = 0; first_req = -1;
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1; chk_en = 1'b1;
  endtask

  task automatic wait_halt(input string nm);
    int k;
    k = 0;
    while (!halted && k < 400) begin @(posedge clk); k++; end
    chk(nm, halted, 1'b1);
  endtask

  task automatic clear_mem(input logic [15:0] dv);
    for (int i = 0; i < 256; i++) begin imem[i] = HALT_W; dmem[i] = dv; end
  endtask

  initial begin
    int k, q;
    int a6q [$];
    rst_n = 1'b0; rst6_n = 1'b0;
    ack6 = 1'b1; rdata6 = 16'h2000; dack6 = 1'b0; drdata6 = 16'h0;

    // Reset values
    #12;
    chk("rst_imem", {imem_req, imem_addr}, 17'h0);
    chk("rst_dmem", {dmem_req, dmem_we, dmem_addr, dmem_wdata}, 34'h0);
    chk("rst_flags", {retire, halted}, 2'b00);

    // Program 1: ALU, LUI, r0 discard, stores, halt; zero wait
    clear_mem(16'h1234);
    imem[0]  = rri(T_ADDI, 1, 0, 5);
    imem[1]  = rri(T_ADDI, 2, 1, -3);
    imem[2]  = ri(T_LUI, 3, 10'h3FF);
    imem[3]  = rri(T_ADDI, 3, 3, 63);
    imem[4]  = rrr(T_ADD, 4, 3, 3);
    imem[5]  = rri(T_ADDI, 0, 0, 7);
    imem[6]  = rri(T_SW, 2, 0, 0);
    imem[7]  = rri(T_SW, 3, 0, 1);
    imem[8]  = rri(T_SW, 4, 0, 2);
    imem[9]  = rri(T_SW, 0, 0, 3);
    imem[10] = rrr(T_NAND, 6, 3, 2);
    imem[11] = rri(T_SW, 6, 0, 4);
    imem[12] = rri(T_JALR, 0, 0, 1);
    start(0, 0);
    wait_halt("p1_halt_timeout");
    chk("p1_first_req_cycle", first_req, 2);
    chk("p1_first_retire_cycle", retire_q.size() > 0 ? retire_q[0] : -1, 3);
    chk("p1_retire_spacing", retire_q.size() > 1 ? retire_q[1] - retire_q[0] : -1, 2);
    chk("p1_model_r2", m_regs[2], 16'h0002);
    chk("p1_model_r4", m_regs[4], 16'hFFFE);
    chk("p1_mem0", dmem[0], 16'h0002);
    chk("p1_mem1", dmem[1], 16'hFFFF);
    chk("p1_mem2", dmem[2], 16'hFFFE);
    chk("p1_mem3_r0", dmem[3], 16'h0000);
    chk("p1_mem4_nand", dmem[4], 16'hFFFD);
    chk("p1_retires", n_ret, 13);
    q = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (imem_req || retire) q++; end
    chk("p1_quiet_after_halt", q, 0);

    // Program 2: store/load with 3 data wait states, 1 fetch wait state
    clear_mem(16'h0000);
    imem[0] = ri(T_LUI, 3, 10'h3FF);
    imem[1] = rri(T_ADDI, 3, 3, 63);
    imem[2] = rri(T_SW, 3, 0, 4);
    imem[3] = rri(T_LW, 5, 0, 4);
    imem[4] = rri(T_SW, 5, 0, 5);
    start(1, 3);
    wait_halt("p2_halt_timeout");
    chk("p2_dreq_cycles", n_dreq, 12);
    chk("p2_sw_to_lw_retire", retire_q.size() > 3 ? retire_q[3] - retire_q[2] : -1, 7);
    chk("p2_mem5", dmem[5], 16'hFFFF);
    chk("p2_model_r5", m_regs[5], 16'hFFFF);
    chk("p2_retires", n_ret, 6);

    // Program 3: branches, JALR link/jump, self-loop; 2 fetch wait states
    clear_mem(16'h0000);
    imem[0]     = rri(T_ADDI, 1, 0, 32);
    imem[1]     = rri(T_BEQ, 1, 0, 2);
    imem[2]     = rri(T_BEQ, 0, 0, 2);
    imem[5]     = rri(T_JALR, 1, 1, 0);
    imem[8'h20] = rri(T_SW, 1, 0, 0);
    imem[8'h21] = rri(T_ADDI, 3, 0, 16);
    imem[8'h22] = rri(T_JALR, 4, 3, 0);
    imem[8'h10] = rri(T_BEQ, 0, 0, -1);
    start(2, 0);
    k = 0;
    while (n_ret < 10 && k < 400) begin @(posedge clk); k++; end
    chk("p3_retire_timeout", n_ret >= 10, 1'b1);
    k = 0;
    do begin @(negedge clk); k++; end while (!imem_req && k < 20);
    chk("p3_loop_fetch", imem_addr, 16'h0010);
    chk("p3_model_pc", m_pc, 16'h0010);
    chk("p3_model_link", m_regs[4], 16'h0023);
    chk("p3_mem0_jalr_link", dmem[0], 16'h0006);

    // Asynchronous reset while a fetch is waiting for ack
    imem_lat = 5;
    k = 0;
    do begin @(negedge clk); k++; end while (!(imem_req && !imem_ack) && k < 20);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_imem_req", imem_req, 1'b0);
    chk("abort_pc", imem_addr, 16'h0000);
    chk("abort_flags", {retire, halted, dmem_req}, 3'b000);

    // Program 4: dump registers after reset
    clear_mem(16'h5555);
    for (int i = 0; i < 7; i++) imem[i] = rri(T_SW, 3'(i + 1), 0, i);
    start(0, 0);
    wait_halt("p4_halt_timeout");
    q = 0;
    for (int i = 0; i < 7; i++) q += (dmem[i] == 16'h0000) ? 1 : 0;
    chk("p4_regs_cleared", q, 7);
    chk("p4_retires", n_ret, 8);

    // 6-bit PC wraps from 63 to 0
    chk_en = 1'b0;
    repeat (2) @(posedge clk);
    #2; rst6_n = 1'b1;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (req6) a6q.push_back(int'(addr6)); end
    chk("w6_fetch_count", a6q.size() >= 4, 1'b1);
    if (a6q.size() >= 4) begin
      chk("w6_fetch0", a6q[0], 62);
      chk("w6_fetch1", a6q[1], 63);
      chk("w6_fetch2_wrap", a6q[2], 0);
      chk("w6_fetch3", a6q[3], 1);
    end
    chk("w6_no_data", {dreq6, dwe6, daddr6, dwdata6, halt6, ret6}, 25'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/risc16_mc_core.md
# risc16_mc_core

Parametrised multi-cycle RiSC-16 processor core, successor to the single-cycle core. It replaces the fixed 6-bit PC, hard-wired memories and wait-cycle counter with a configurable address width and variable-latency req/ack ports to external instruction and data memories. It adds a HALT instruction and a retire pulse for trace and verification. It sits at the top of the CPU hierarchy; the SRAM macros and any wait-state logic live outside it.

## Interface
- ADDR_W, default 16: width of the PC and of both memory addresses (1..16); addresses are the low ADDR_W bits of the 16-bit computed value.
- RESET_PC, default 0: PC value loaded on reset (ADDR_W bits).

- clk0  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_W  fetch address; equals PC at all times.
- imem_ack  in  1  fetch complete; imem_rdata valid in the same cycle.
- imem_rdata  in  16  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req is high.
- dmem_addr  out  ADDR_W  data address.
- dmem_wdata  out  16  store data.
- dmem_ack  in  1  access complete; dmem_rdata valid in the same cycle for loads.
- dmem_rdata  in  16  load data.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  high from HALT retirement until reset.

## Operation
- ISA is RiSC-16. Fields: op [15:13], rA [12:10], rB [9:7], rC [2:0], simm7 [6:0] (sign-extended to 16), imm10 [9:0].
- ADD: rA=rB+rC. ADDI: rA=rB+simm7. NAND: rA=~(rB&rC). LUI: rA={imm10,6'b0}.
- SW: mem[rB+simm7]=rA. LW: rA=mem[rB+simm7].
- BEQ: if rA==rB then PC=PC+1+simm7, else PC=PC+1.
- JALR with simm7==0: rA=PC+1, PC=rB. Both operands are read before the write, so JALR rA==rB jumps to the old value.
- JALR with simm7!=0 is HALT: retires, enters HALT, PC unchanged.
- Data arithmetic is 16-bit with wrap-around. PC arithmetic is modulo 2^ADDR_W. Data addresses are truncated to ADDR_W bits.
- Writes to r0 are discarded; r0 always reads 0.
- States:
  - FETCH: imem_req=1. On imem_ack, latch the IR and go to EXEC.
  - EXEC: decode and execute. ALU, LUI, BEQ and JALR write rA and update PC this cycle, pulse retire, and go to FETCH. LW/SW latch address and data and go to MEM. HALT goes to HALT.
  - MEM: dmem_req=1. On dmem_ack, LW writes rA, PC=PC+1, retire pulses, and the core goes to FETCH.
  - HALT: terminal. No requests; halted=1.
- Handshake rules:
  - req, addr, we and wdata stay stable from req rise until the cycle ack is sampled high.
  - ack in the first req cycle is legal (zero wait).
  - ack while req is low is ignored.
  - req drops in the cycle after ack.
- Reset values: state=FETCH, PC=RESET_PC, r0..r7=0, IR=0, imem_req=0 during reset, all dmem outputs 0, retire=0, halted=0.
- Reset assertion mid-transaction aborts it immediately and asynchronously; the core does not wait for an outstanding ack.

## Timing
- req outputs decode from the state register only; there is no combinational path from ack to req.
- imem_req rises in the first clk0 edge cycle after reset deasserts.
- Zero-wait latency:
  - ALU/LUI/BEQ/JALR: 2 cycles (FETCH, EXEC).
  - LW/SW: 3 cycles (FETCH, EXEC, MEM).
- Each memory wait cycle adds 1 cycle.
- retire is high in the EXEC cycle (non-memory) or the MEM ack cycle (LW/SW). Register and PC updates are visible from the next cycle.

## Structure
- Package risc16_pkg:
  - opcode localparams OP_ADD..OP_JALR
  - state enum (FETCH, EXEC, MEM, HALT)
  - field-extract functions and the sext7 function
- Sub-module risc16_regfile: 8x16 registers, two asynchronous read ports, one synchronous write port, r0 hard-zero, async active-low reset clears all entries.
- ALU, next-PC logic and FSM are inline in the core.

## Test plan
- Reset, then ADDI r1,r0,5; ADDI r2,r1,-3 with zero-wait imem -> r2=0x0002, two retire pulses 2 cycles apart, second fetch at address 1.
- LUI r3,0x3FF; ADDI r3,r3,63; ADD r4,r3,r3 -> r3=0xFFFF, r4=0xFFFE; ADDI r0,r0,7 leaves r0=0.
- SW r3 at r0+4, then LW r5 from r0+4, with dmem_ack delayed 3 cycles -> dmem_req/addr/wdata stable for 4 cycles, r5=0xFFFF only after ack, retire on the ack cycles only.
- BEQ r0,r0,-1 at PC 0x0010 -> next fetch 0x0010. BEQ r1,r0 with r1!=0 -> 0x0011. ADDR_W=6 with PC=63 non-branch -> next fetch 0.
- JALR r1,r1 with r1=0x0020 at PC 0x0005 -> r1=0x0006, next fetch 0x0020. JALR with simm7=1 -> halted=1, retire once, no further imem_req for 20 cycles.
- Reset asserted while imem_req is high and ack is pending -> imem_req low in the same cycle, PC=RESET_PC, registers 0. After release, fetch restarts at RESET_PC.
